tone_gen: RTL and testbench

Square-wave tone generator that sits directly downstream of the note-entry stage (free-play and auto-play front ends). It latches one note request (octave, note, length, volume), drives the buzzer at the note's pitch with PWM volume gating for a fixed duration, and raises `over` when it finishes. The controller keeps `en` high for the whole note by OR-ing its request pulse with `~over`.

---
 rtl/tone_gen.sv | 171 +++++++++++++++++
 tb/tb_tone_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Square-wave tone generator: latches one note request, drives the buzzer at the
// note's pitch with 8-step PWM volume gating for (length+1) units, then raises over.
module tone_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned UNIT_TICKS = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] octave,
    input  logic [2:0] note,
    input  logic [2:0] length,
    input  logic [2:0] volume,
    output logic       buzzer,
    output logic       over
);

    // Mid-octave half-periods in clock cycles, C..B
    localparam int unsigned HP_C = CLK_HZ / (2 * 262);
    localparam int unsigned HP_D = CLK_HZ / (2 * 294);
    localparam int unsigned HP_E = CLK_HZ / (2 * 330);
    localparam int unsigned HP_F = CLK_HZ / (2 * 349);
    localparam int unsigned HP_G = CLK_HZ / (2 * 392);
    localparam int unsigned HP_A = CLK_HZ / (2 * 440);
    localparam int unsigned HP_B = CLK_HZ / (2 * 494);

    localparam int unsigned HP_LOW_MAX = 2 * HP_C;
    localparam int unsigned TONE_W     = (HP_LOW_MAX > 1) ? $clog2(HP_LOW_MAX) : 1;
    localparam int unsigned DUR_MAX    = 8 * UNIT_TICKS;
    localparam int unsigned DUR_W      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          oct_q, oct_d;
    logic [2:0]          note_q, note_d;
    logic [2:0]          len_q, len_d;
    logic [2:0]          vol_q, vol_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic [2:0]          pwm_q, pwm_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                phase_q, phase_d;
    logic                buzzer_d, over_d;

    logic [31:0]         hp_mid_c;
    logic [31:0]         hp_sel_c;
    logic [31:0]         dur_last_c;
    logic                tone_wrap_c;
    logic                dur_done_c;

    // Half-period lookup for the latched note; rests reuse C so the counter stays sane
    always_comb begin
        hp_mid_c = 32'(HP_C);
        case (note_q)
            3'd2:    hp_mid_c = 32'(HP_D);
            3'd3:    hp_mid_c = 32'(HP_E);
            3'd4:    hp_mid_c = 32'(HP_F);
            3'd5:    hp_mid_c = 32'(HP_G);
            3'd6:    hp_mid_c = 32'(HP_A);
            3'd7:    hp_mid_c = 32'(HP_B);
            default: hp_mid_c = 32'(HP_C);
        endcase
    end

    // Octave scaling: low doubles the half-period, high halves it, 3 plays as mid
    always_comb begin
        hp_sel_c = hp_mid_c;
        case (oct_q)
            2'd0:    hp_sel_c = hp_mid_c << 1;
            2'd2:    hp_sel_c = hp_mid_c >> 1;
            default: hp_sel_c = hp_mid_c;
        endcase
    end

    assign dur_last_c  = (32'(len_q) + 32'd1) * 32'(UNIT_TICKS) - 32'd1;
    assign tone_wrap_c = (32'(tone_q) == (hp_sel_c - 32'd1));
    assign dur_done_c  = (32'(dur_q) == dur_last_c);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        oct_d    = oct_q;
        note_d   = note_q;
        len_d    = len_q;
        vol_d    = vol_q;
        tone_d   = tone_q;
        pwm_d    = pwm_q;
        dur_d    = dur_q;
        phase_d  = phase_q;
        buzzer_d = buzzer;
        over_d   = over;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = PLAY;
                    oct_d    = octave;
                    note_d   = note;
                    len_d    = length;
                    vol_d    = volume;
                    tone_d   = '0;
                    pwm_d    = '0;
                    dur_d    = '0;
                    phase_d  = 1'b1;
                    buzzer_d = 1'b0;
                    over_d   = 1'b0;
                end
            end
            PLAY: begin
                // Abort (en low) and normal completion share the same exit
                if (!en || dur_done_c) begin
                    state_d  = IDLE;
                    tone_d   = '0;
                    pwm_d    = '0;
                    dur_d    = '0;
                    phase_d  = 1'b0;
                    buzzer_d = 1'b0;
                    over_d   = 1'b1;
                end else begin
                    buzzer_d = phase_q & (pwm_q < vol_q) & (note_q != 3'd0);
                    pwm_d    = pwm_q + 3'd1;
                    dur_d    = dur_q + DUR_W'(1);
                    if (tone_wrap_c) begin
                        tone_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        tone_d  = tone_q + TONE_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
                over_d   = 1'b1;
            end
        endcase
    end

    // State, latches, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            oct_q   <= '0;
            note_q  <= '0;
            len_q   <= '0;
            vol_q   <= '0;
            tone_q  <= '0;
            pwm_q   <= '0;
            dur_q   <= '0;
            phase_q <= 1'b0;
            buzzer  <= 1'b0;
            over    <= 1'b1;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
            note_q  <= note_d;
            len_q   <= len_d;
            vol_q   <= vol_d;
            tone_q  <= tone_d;
            pwm_q   <= pwm_d;
            dur_q   <= dur_d;
            phase_q <= phase_d;
            buzzer  <= buzzer_d;
            over    <= over_d;
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: every cycle of each note is compared against an
// arithmetic model of pitch, PWM gating and duration derived from the note parameters.
module tb_tone_gen;

    localparam int unsigned CLK_HZ     = 10_000;
    localparam int unsigned UNIT_TICKS = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] octave = '0;
    logic [2:0] note = '0;
    logic [2:0] length = '0;
    logic [2:0] volume = '0;
    logic       buzzer;
    logic       over;

    int checks = 0;
    int errors = 0;

    tone_gen #(.CLK_HZ(CLK_HZ), .UNIT_TICKS(UNIT_TICKS)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .octave (octave),
        .note   (note),
        .length (length),
        .volume (volume),
        .buzzer (buzzer),
        .over   (over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Half-period from the musical frequency table and octave rule
    function automatic int unsigned model_hp(input int unsigned o, input int unsigned n);
        int unsigned freq [7] = '{262, 294, 330, 349, 392, 440, 494};
        int unsigned mid;
        mid = CLK_HZ / (2 * freq[(n == 0) ? 0 : n - 1]);
        if (o == 0) return mid * 2;
        if (o == 2) return mid / 2;
        return mid;
    endfunction

    // Expected buzzer level m cycles after the start edge (1 <= m < D)
    function automatic logic model_buzz(input int unsigned o, input int unsigned n,
                                        input int unsigned v, input int unsigned m);
        int unsigned hp;
        logic phase_hi;
        hp = model_hp(o, n);
        phase_hi = (((m - 1) / hp) % 2) == 0;
        return (n != 0) && phase_hi && (((m - 1) % 8) < v);
    endfunction

    // Plays one note; inputs are scrambled every cycle after the start to prove latching.
    // abort_at=0 means no abort; b2b leaves en high into the next call.
    task automatic play_note(input logic [1:0] o, input logic [2:0] n, input logic [2:0] l,
                             input logic [2:0] v, input int unsigned abort_at, input bit b2b,
                             input string name);
        int unsigned d;
        d = (int'(l) + 1) * UNIT_TICKS;
        octave = o; note = n; length = l; volume = v; en = 1'b1;
        @(posedge clk); #1;
        chk({name, " start over"}, over, 1'b0);
        chk({name, " start buzzer"}, buzzer, 1'b0);
        for (int unsigned m = 1; m <= d; m++) begin
            octave = 2'($urandom); note = 3'($urandom);
            length = 3'($urandom); volume = 3'($urandom);
            en = 1'b1;
            if (abort_at == m) en = 1'b0;
            if (m == d && !b2b) en = 1'b0;
            @(posedge clk); #1;
            if (abort_at == m || m == d) begin
                chk($sformatf("%s end over m=%0d", name, m), over, 1'b1);
                chk($sformatf("%s end buzzer m=%0d", name, m), buzzer, 1'b0);
                break;
            end
            chk($sformatf("%s over m=%0d", name, m), over, 1'b0);
            chk($sformatf("%s buzzer m=%0d", name, m), buzzer,
                model_buzz(int'(o), int'(n), int'(v), m));
        end
        if (!b2b) begin
            en = 1'b0;
            @(posedge clk); #1;
            chk({name, " idle over"}, over, 1'b1);
            chk({name, " idle buzzer"}, buzzer, 1'b0);
        end
    endtask

    initial begin
        // Reset held with en high: no start, outputs at reset values
        rst = 1'b1; en = 1'b1;
        octave = 2'd1; note = 3'd6; volume = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("reset over %0d", i), over, 1'b1);
            chk($sformatf("reset buzzer %0d", i), buzzer, 1'b0);
        end
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk("post-reset idle over", over, 1'b1);
        chk("post-reset idle buzzer", buzzer, 1'b0);

        // Pitch and volume: mid A, full volume
        play_note(2'd1, 3'd6, 3'd0, 3'd7, 0, 1'b0, "midA");

        // Octave mapping with C, plus the longest length
        play_note(2'd0, 3'd1, 3'd0, 3'd4, 0, 1'b0, "lowC");
        play_note(2'd2, 3'd1, 3'd0, 3'd4, 0, 1'b0, "highC");
        play_note(2'd3, 3'd1, 3'd0, 3'd4, 0, 1'b0, "oct3C");
        play_note(2'd1, 3'd1, 3'd7, 3'($urandom_range(1, 7)), 0, 1'b0, "len7");

        // Silence: zero volume, then rest at full volume
        play_note(2'd1, 3'd3, 3'd0, 3'd0, 0, 1'b0, "vol0");
        play_note(2'd1, 3'd0, 3'd0, 3'd7, 0, 1'b0, "rest");

        // Abort at PLAY cycle 50, then a fresh note with new parameters
        play_note(2'd1, 3'd5, 3'd3, 3'd5, 50, 1'b0, "abort");
        play_note(2'd2, 3'd7, 3'd0, 3'd3, 0, 1'b0, "after-abort");

        // Back-to-back notes with en held across the boundary
        play_note(2'd1, 3'd2, 3'd0, 3'd6, 0, 1'b1, "b2b-1");
        play_note(2'd0, 3'd4, 3'd0, 3'd2, 0, 1'b1, "b2b-2");
        play_note(2'd2, 3'd6, 3'd0, 3'd7, 0, 1'b0, "b2b-3");

        // Randomized notes, some aborted early
        for (int i = 0; i < 8; i++) begin
            logic [1:0] ro;
            logic [2:0] rn, rl, rv;
            int unsigned ra;
            ro = 2'($urandom); rn = 3'($urandom);
            rl = 3'($urandom_range(0, 1)); rv = 3'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : 0;
            play_note(ro, rn, rl, rv, ra, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
        en = 1'b0;
        @(posedge clk); #1;
        chk("rand tail over", over, 1'b1);

        // Reset mid-note wins over en
        octave = 2'd1; note = 3'd1; length = 3'd2; volume = 3'd7; en = 1'b1;
        @(posedge clk); #1;
        chk("midreset start over", over, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset over", over, 1'b1);
        chk("midreset buzzer", buzzer, 1'b0);
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk("midreset idle over", over, 1'b1);
        play_note(2'd1, 3'd6, 3'd0, 3'd7, 0, 1'b0, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
